// File: rtl/seq_div8x4_pkg.sv
// Shared types and defaults for the sequential restoring divider.
// State codes stay as plain constants so legacy code that compares raw encodings still works.
package div_pkg;

    localparam int unsigned N_W_DEF = 8;
    localparam int unsigned D_W_DEF = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_div8x4_if.sv
// Start/result handshake bundle between the controller and the divider.
interface seq_div8x4_if #(
    parameter int unsigned N_W = 8,
    parameter int unsigned D_W = 4
);
    logic           pstart;
    logic [N_W-1:0] pn;
    logic [D_W-1:0] pd;
    logic           pready;
    logic           pbusy;
    logic           pdz;
    logic [N_W-1:0] pq;
    logic [D_W-1:0] pr;

    modport master (
        output pstart, pn, pd,
        input  pready, pbusy, pdz, pq, pr
    );

    modport slave (
        input  pstart, pn, pd,
        output pready, pbusy, pdz, pq, pr
    );
endinterface

// File: rtl/seq_div8x4_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned D_W = 4
) (
    input  logic [D_W-1:0] rem,
    input  logic           nbit,
    input  logic [D_W-1:0] d,
    output logic [D_W-1:0] rem_next,
    output logic           qbit
);
    logic [D_W:0] trial;

    // rem < d on entry, so both the trial result and the restored value fit in D_W bits.
    always_comb begin
        trial    = {rem, nbit} - {1'b0, d};
        qbit     = ~trial[D_W];
        rem_next = qbit ? trial[D_W-1:0] : {rem[D_W-2:0], nbit};
    end
endmodule

// File: rtl/seq_div8x4.sv
// Sequential restoring divider, one quotient bit per clock MSB first, pstart/pready handshake.
module seq_div8x4
    import div_pkg::*;
#(
    parameter int unsigned N_W = N_W_DEF,
    parameter int unsigned D_W = D_W_DEF
) (
    input logic         clock,
    input logic         reset,
    seq_div8x4_if.slave bus
);
    localparam int unsigned CNT_W = cnt_width(N_W);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [N_W-1:0]   n_reg;
    logic [N_W-1:0]   n_next;
    logic [D_W-1:0]   d_reg;
    logic [D_W-1:0]   rem_reg;
    logic [D_W-1:0]   rem_next;
    logic             qbit;
    logic [N_W-1:0]   q_reg;
    logic [D_W-1:0]   r_reg;
    logic             dz_reg;

    div_step #(.D_W(D_W)) u_step (
        .rem      (rem_reg),
        .nbit     (n_reg[N_W-1]),
        .d        (d_reg),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // Dividend bits leave at the top while quotient bits enter at the bottom.
    assign n_next = {n_reg[N_W-2:0], qbit};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            n_reg   <= '0;
            d_reg   <= '0;
            rem_reg <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            dz_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.pstart) begin
                        if (bus.pd != '0) begin
                            n_reg   <= bus.pn;
                            d_reg   <= bus.pd;
                            rem_reg <= '0;
                            count   <= CNT_W'(N_W - 1);
                            dz_reg  <= 1'b0;
                            state   <= RUN;
                        end else begin
                            q_reg  <= '1;
                            r_reg  <= '0;
                            dz_reg <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                RUN: begin
                    n_reg   <= n_next;
                    rem_reg <= rem_next;
                    count   <= count - CNT_W'(1);
                    if (count == '0) begin
                        q_reg <= n_next;
                        r_reg <= rem_next;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pready = (state == DONE);
    assign bus.pbusy  = (state == RUN);
    assign bus.pdz    = dz_reg;
    assign bus.pq     = q_reg;
    assign bus.pr     = r_reg;
endmodule

// File: tb/tb_seq_div8x4.sv
// Directed and random checks of seq_div8x4 against hand-computed quotient/remainder values.
module tb_seq_div8x4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    seq_div8x4_if #(.N_W(8), .D_W(4)) bus ();

    seq_div8x4 #(.N_W(8), .D_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulses pstart for one accepting edge; lat = posedges from drive until pready is seen.
    task automatic run_op(input logic [7:0] n, input logic [3:0] d, output int lat, output int busy);
        @(negedge clock);
        bus.pstart = 1'b1;
        bus.pn     = n;
        bus.pd     = d;
        @(posedge clock);
        @(negedge clock);
        bus.pstart = 1'b0;
        lat  = 1;
        busy = 0;
        while (!bus.pready && lat < 40) begin
            if (bus.pbusy) busy++;
            @(negedge clock);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int busy;
        int low;
        logic [7:0] rn;
        logic [3:0] rd;

        bus.pstart = 1'b0;
        bus.pn     = '0;
        bus.pd     = '0;

        #2;
        chk("rst_pready", 32'(bus.pready), 0);
        chk("rst_pbusy",  32'(bus.pbusy),  0);
        chk("rst_pq",     32'(bus.pq),     0);
        chk("rst_pr",     32'(bus.pr),     0);
        chk("rst_pdz",    32'(bus.pdz),    0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        run_op(8'd200, 4'd7, lat, busy);
        chk("200/7_lat",  32'(lat),     9);
        chk("200/7_busy", 32'(busy),    8);
        chk("200/7_q",    32'(bus.pq),  28);
        chk("200/7_r",    32'(bus.pr),  4);
        chk("200/7_dz",   32'(bus.pdz), 0);

        run_op(8'd255, 4'd1, lat, busy);
        chk("255/1_q", 32'(bus.pq), 255);
        chk("255/1_r", 32'(bus.pr), 0);

        run_op(8'd5, 4'd15, lat, busy);
        chk("5/15_q", 32'(bus.pq), 0);
        chk("5/15_r", 32'(bus.pr), 5);

        run_op(8'd0, 4'd9, lat, busy);
        chk("0/9_q", 32'(bus.pq), 0);
        chk("0/9_r", 32'(bus.pr), 0);

        run_op(8'd9, 4'd0, lat, busy);
        chk("9/0_lat",  32'(lat),     1);
        chk("9/0_busy", 32'(busy),    0);
        chk("9/0_dz",   32'(bus.pdz), 1);
        chk("9/0_q",    32'(bus.pq),  32'hFF);
        chk("9/0_r",    32'(bus.pr),  0);

        run_op(8'd100, 4'd10, lat, busy);
        chk("100/10_dz", 32'(bus.pdz), 0);
        chk("100/10_q",  32'(bus.pq),  10);
        chk("100/10_r",  32'(bus.pr),  0);

        // pstart and operands wiggle during RUN; only the captured 200/7 must complete.
        @(negedge clock);
        bus.pstart = 1'b1;
        bus.pn     = 8'd200;
        bus.pd     = 4'd7;
        @(posedge clock);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("mid_busy",   32'(bus.pbusy),  1);
            chk("mid_hold_q", 32'(bus.pq),     10);
            chk("mid_hold_r", 32'(bus.pr),     0);
            bus.pstart = (i < 7) ? ((i % 2) == 0) : 1'b0;
            bus.pn     = 8'(i * 37 + 3);
            bus.pd     = 4'(i);
        end
        @(negedge clock);
        chk("mid_ready", 32'(bus.pready), 1);
        chk("mid_q",     32'(bus.pq),     28);
        chk("mid_r",     32'(bus.pr),     4);
        repeat (3) @(negedge clock);
        chk("mid_single_ready", 32'(bus.pready), 1);
        chk("mid_stable_q",     32'(bus.pq),     28);

        // Asynchronous abort in the fourth RUN cycle.
        @(negedge clock);
        bus.pstart = 1'b1;
        bus.pn     = 8'd200;
        bus.pd     = 4'd7;
        @(posedge clock);
        @(negedge clock);
        bus.pstart = 1'b0;
        repeat (3) @(negedge clock);
        chk("abort_busy_before", 32'(bus.pbusy), 1);
        reset = 1'b1;
        #1;
        chk("abort_pready", 32'(bus.pready), 0);
        chk("abort_pbusy",  32'(bus.pbusy),  0);
        chk("abort_pq",     32'(bus.pq),     0);
        chk("abort_pr",     32'(bus.pr),     0);
        chk("abort_pdz",    32'(bus.pdz),    0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("abort_idle_pready", 32'(bus.pready), 0);

        run_op(8'd15, 4'd4, lat, busy);
        chk("15/4_lat", 32'(lat),    9);
        chk("15/4_q",   32'(bus.pq), 3);
        chk("15/4_r",   32'(bus.pr), 3);

        // Back-to-back: pstart stays high straight through DONE.
        @(negedge clock);
        bus.pstart = 1'b1;
        bus.pn     = 8'd77;
        bus.pd     = 4'd5;
        @(posedge clock);
        lat = 1;
        @(negedge clock);
        while (!bus.pready && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        chk("b2b_first_lat", 32'(lat),    9);
        chk("b2b_first_q",   32'(bus.pq), 15);
        chk("b2b_first_r",   32'(bus.pr), 2);
        bus.pd = 4'd6;
        @(posedge clock);
        @(negedge clock);
        low = 0;
        while (!bus.pready && low < 40) begin
            if (low == 0) chk("b2b_hold_q", 32'(bus.pq), 15);
            low++;
            @(negedge clock);
        end
        bus.pstart = 1'b0;
        chk("b2b_low_cycles", 32'(low),    8);
        chk("b2b_second_q",   32'(bus.pq), 12);
        chk("b2b_second_r",   32'(bus.pr), 5);

        for (int k = 0; k < 500; k++) begin
            rn = 8'($urandom_range(0, 255));
            rd = 4'($urandom_range(0, 15));
            run_op(rn, rd, lat, busy);
            if (rd == 4'd0) begin
                chk("rnd_dz_q",  32'(bus.pq),  32'hFF);
                chk("rnd_dz_f",  32'(bus.pdz), 1);
            end else begin
                chk("rnd_q",     32'(bus.pq),  32'(rn) / 32'(rd));
                chk("rnd_r",     32'(bus.pr),  32'(rn) % 32'(rd));
                chk("rnd_recon", 32'(bus.pq) * 32'(rd) + 32'(bus.pr), 32'(rn));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
